// File: rtl/mem_port_arbiter.sv
// N-client request/response arbiter onto one in-order memory port with an ordered tag FIFO.
// Optional round-robin arbitration via `define MEM_ARB_ROUND_ROBIN_EN (default: fixed priority, lowest index wins).
module mem_port_arbiter #(
  parameter int unsigned NUM_CLIENTS     = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CLIENTS-1:0]             cli_req_valid,
  output logic [NUM_CLIENTS-1:0]             cli_req_ready,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]      cli_req_bits_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0]      cli_req_bits_data,
  input  logic [NUM_CLIENTS-1:0]             cli_req_bits_fcn,
  input  logic [NUM_CLIENTS*3-1:0]           cli_req_bits_typ,
  output logic [NUM_CLIENTS-1:0]             cli_resp_valid,
  output logic [DATA_W-1:0]                  cli_resp_bits_data,
  input  logic                               mem_req_ready,
  output logic                               mem_req_valid,
  output logic [ADDR_W-1:0]                  mem_req_bits_addr,
  output logic [DATA_W-1:0]                  mem_req_bits_data,
  output logic                               mem_req_bits_fcn,
  output logic [2:0]                         mem_req_bits_typ,
  input  logic                               mem_resp_valid,
  input  logic [DATA_W-1:0]                  mem_resp_bits_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unexpected_resp
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_e;

  lock_state_e      state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] winner, grant, head_tag;
  logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q, full, locked, fire, push, pop;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q;
  int               rr_best, rr_dist;

  // Pick the valid client closest (ascending, wrapping) to rr_ptr.
  always_comb begin
    winner  = '0;
    rr_best = int'(NUM_CLIENTS);
    rr_dist = 0;
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      if (cli_req_valid[i]) begin
        rr_dist = (i >= int'(rr_ptr_q)) ? (i - int'(rr_ptr_q))
                                        : (i + int'(NUM_CLIENTS) - int'(rr_ptr_q));
        if (rr_dist < rr_best) begin
          rr_best = rr_dist;
          winner  = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (fire) begin
      rr_ptr_q <= (grant == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant + IDX_W'(1);
    end
  end
`else
  // Fixed priority: descending scan so the lowest valid index is written last.
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_CLIENTS) - 1; i >= 0; i--) begin
      if (cli_req_valid[i]) winner = IDX_W'(i);
    end
  end
`endif

  assign locked        = (state_q == ST_LOCKED);
  assign grant         = locked ? lock_idx_q : winner;
  assign full          = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign mem_req_valid = !full && (locked ? cli_req_valid[lock_idx_q] : |cli_req_valid);
  assign fire          = mem_req_valid && mem_req_ready;
  assign push          = fire;
  assign pop           = mem_resp_valid && (count_q != '0);
  assign head_tag      = tag_mem[head_q];

  // Request field mux and per-client ready from the granted client.
  always_comb begin
    mem_req_bits_addr = '0;
    mem_req_bits_data = '0;
    mem_req_bits_fcn  = 1'b0;
    mem_req_bits_typ  = '0;
    cli_req_ready     = '0;
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      if (grant == IDX_W'(i)) begin
        mem_req_bits_addr = cli_req_bits_addr[i*ADDR_W +: ADDR_W];
        mem_req_bits_data = cli_req_bits_data[i*DATA_W +: DATA_W];
        mem_req_bits_fcn  = cli_req_bits_fcn[i];
        mem_req_bits_typ  = cli_req_bits_typ[i*3 +: 3];
        cli_req_ready[i]  = mem_req_ready && !full;
      end
    end
  end

  // Lock holds the presented client while memory stalls.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (mem_req_valid && !mem_req_ready) begin
          state_d    = ST_LOCKED;
          lock_idx_d = grant;
        end
      end
      ST_LOCKED: begin
        if (fire || !cli_req_valid[lock_idx_q]) state_d = ST_UNLOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  assign cli_resp_valid      = pop ? (NUM_CLIENTS'(1) << head_tag) : '0;
  assign cli_resp_bits_data  = mem_resp_bits_data;
  assign outstanding         = count_q;
  assign err_unexpected_resp = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      lock_idx_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (mem_resp_valid && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset; head/tail/count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) tag_mem[tail_q] <= grant;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int unsigned NC = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 4;
  localparam int unsigned CW = $clog2(MO) + 1;
  localparam int unsigned IW = $clog2(NC);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     cli_req_valid;
  logic [NC-1:0]     cli_req_ready;
  logic [NC*AW-1:0]  cli_req_bits_addr;
  logic [NC*DW-1:0]  cli_req_bits_data;
  logic [NC-1:0]     cli_req_bits_fcn;
  logic [NC*3-1:0]   cli_req_bits_typ;
  logic [NC-1:0]     cli_resp_valid;
  logic [DW-1:0]     cli_resp_bits_data;
  logic              mem_req_ready;
  logic              mem_req_valid;
  logic [AW-1:0]     mem_req_bits_addr;
  logic [DW-1:0]     mem_req_bits_data;
  logic              mem_req_bits_fcn;
  logic [2:0]        mem_req_bits_typ;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_bits_data;
  logic [CW-1:0]     outstanding;
  logic              err_unexpected_resp;

  always #5 clock = ~clock;

  mem_port_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clock(clock), .reset(reset),
    .cli_req_valid(cli_req_valid), .cli_req_ready(cli_req_ready),
    .cli_req_bits_addr(cli_req_bits_addr), .cli_req_bits_data(cli_req_bits_data),
    .cli_req_bits_fcn(cli_req_bits_fcn), .cli_req_bits_typ(cli_req_bits_typ),
    .cli_resp_valid(cli_resp_valid), .cli_resp_bits_data(cli_resp_bits_data),
    .mem_req_ready(mem_req_ready), .mem_req_valid(mem_req_valid),
    .mem_req_bits_addr(mem_req_bits_addr), .mem_req_bits_data(mem_req_bits_data),
    .mem_req_bits_fcn(mem_req_bits_fcn), .mem_req_bits_typ(mem_req_bits_typ),
    .mem_resp_valid(mem_resp_valid), .mem_resp_bits_data(mem_resp_bits_data),
    .outstanding(outstanding), .err_unexpected_resp(err_unexpected_resp)
  );

  // Reference model state: queue of issuing clients, in request order.
  logic [IW-1:0] q[$];
  bit            m_err, m_lock, m_init;
  logic [IW-1:0] m_lock_c;
  int            m_rr;
  int            checks = 0;
  int            passes = 0;
  logic [NC-1:0] prev_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [IW-1:0] exp_grant();
    bit found = 0;
    logic [IW-1:0] g = '0;
    if (m_lock) return m_lock_c;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < int'(NC); k++)
      for (int i = 0; i < int'(NC); i++)
        if (!found && i == (m_rr + k) % int'(NC) && cli_req_valid[i]) begin
          found = 1;
          g = IW'(i);
        end
`else
    for (int i = 0; i < int'(NC); i++)
      if (!found && cli_req_valid[i]) begin
        found = 1;
        g = IW'(i);
      end
`endif
    return g;
  endfunction

  // One clock: check combinational outputs against the model, then advance the model at the edge.
  task automatic cycle();
    bit            full, erv, fire, pop;
    logic [IW-1:0] g;
    logic [NC-1:0] erdy, eresp;
    int            gi;
    #1;
    full  = (q.size() == int'(MO));
    erv   = !full && (m_lock ? cli_req_valid[m_lock_c] : (|cli_req_valid));
    g     = exp_grant();
    gi    = int'(g);
    erdy  = (mem_req_ready && !full) ? (NC'(1) << g) : '0;
    fire  = erv && mem_req_ready;
    pop   = mem_resp_valid && (q.size() > 0);
    eresp = pop ? (NC'(1) << q[0]) : '0;
    if (m_init) begin
      check_eq("mem_req_valid", mem_req_valid, erv);
      if (m_lock || (|cli_req_valid)) check_eq("cli_req_ready", cli_req_ready, erdy);
      if (erv) begin
        check_eq("req_addr", mem_req_bits_addr, cli_req_bits_addr[gi*AW +: AW]);
        check_eq("req_data", mem_req_bits_data, cli_req_bits_data[gi*DW +: DW]);
        check_eq("req_fcn_typ", {mem_req_bits_fcn, mem_req_bits_typ},
                 {cli_req_bits_fcn[gi], cli_req_bits_typ[gi*3 +: 3]});
      end
      check_eq("cli_resp_valid", cli_resp_valid, eresp);
      check_eq("cli_resp_data", cli_resp_bits_data, mem_resp_bits_data);
      check_eq("outstanding", outstanding, q.size());
      check_eq("err", err_unexpected_resp, m_err);
    end
    prev_ready = cli_req_ready;
    @(posedge clock);
    if (reset) begin
      q.delete();
      m_err  = 0;
      m_lock = 0;
      m_rr   = 0;
      m_init = 1;
    end else begin
      if (pop) void'(q.pop_front());
      else if (mem_resp_valid) m_err = 1;
      if (fire) begin
        q.push_back(g);
        m_rr = (gi + 1) % int'(NC);
      end
      if (!m_lock && erv && !mem_req_ready) begin
        m_lock   = 1;
        m_lock_c = g;
      end else if (m_lock && (fire || !cli_req_valid[m_lock_c])) begin
        m_lock = 0;
      end
    end
    @(negedge clock);
  endtask

  task automatic drive(input logic [NC-1:0] v, input logic rdy, input logic rv, input logic [DW-1:0] rd);
    cli_req_valid      = v;
    mem_req_ready      = rdy;
    mem_resp_valid     = rv;
    mem_resp_bits_data = rd;
  endtask

  initial begin
    m_init = 0; m_err = 0; m_lock = 0; m_rr = 0; m_lock_c = '0;
    cli_req_bits_addr = '0; cli_req_bits_data = '0; cli_req_bits_fcn = '0; cli_req_bits_typ = '0;
    drive('0, 1'b0, 1'b0, '0);
    @(negedge clock);
    cycle();
    drive(2'b01, 1'b0, 1'b0, '0);
    cycle();
    reset = 1'b0;
    drive('0, 1'b1, 1'b0, '0);
    #1;
    check_eq("rst_outstanding", outstanding, 0);
    check_eq("rst_err", err_unexpected_resp, 0);
    check_eq("rst_mem_req_valid", mem_req_valid, 0);
    cycle();

    // Single client read with a later response.
    cli_req_bits_addr[0 +: AW]  = 32'h100;
    cli_req_bits_addr[AW +: AW] = 32'h200;
    drive(2'b01, 1'b1, 1'b0, '0);
    #1;
    check_eq("single_ready", cli_req_ready, 2'b01);
    check_eq("single_addr", mem_req_bits_addr, 32'h100);
    cycle();
    drive('0, 1'b1, 1'b0, '0);
    cycle();
    drive('0, 1'b1, 1'b1, 32'hDEADBEEF);
    #1;
    check_eq("single_resp_valid", cli_resp_valid, 2'b01);
    check_eq("single_resp_data", cli_resp_bits_data, 32'hDEADBEEF);
    check_eq("single_out_before", outstanding, 1);
    cycle();
    drive('0, 1'b1, 1'b0, '0);
    #1;
    check_eq("single_out_after", outstanding, 0);

    // Contention with ready held high.
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 1'b1, k > 0, DW'(k));
      #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (k > 0) check_eq("rr_alternate", cli_req_ready, ~prev_ready);
`else
      check_eq("fixed_prio", cli_req_ready, 2'b01);
`endif
      cycle();
    end
    drive('0, 1'b1, 1'b1, '0);
    cycle();

    // Stall lock keeps client 1 presented while client 0 arrives.
    drive(2'b10, 1'b0, 1'b0, '0);
    cycle();
    cli_req_bits_addr[0 +: AW] = 32'h300;
    drive(2'b11, 1'b0, 1'b0, '0);
    #1;
    check_eq("lock_addr", mem_req_bits_addr, 32'h200);
    cycle();
    drive(2'b11, 1'b1, 1'b0, '0);
    #1;
    check_eq("lock_ready", cli_req_ready, 2'b10);
    check_eq("lock_addr_fire", mem_req_bits_addr, 32'h200);
    cycle();
    drive('0, 1'b1, 1'b1, 32'h55);
    #1;
    check_eq("lock_resp", cli_resp_valid, 2'b10);
    cycle();

    // Fill to MAX_OUTSTANDING; a pop does not unblock the same cycle.
    for (int k = 0; k < int'(MO); k++) begin
      drive(2'b01, 1'b1, 1'b0, '0);
      cycle();
    end
    #1;
    check_eq("full_valid", mem_req_valid, 0);
    check_eq("full_ready", cli_req_ready, 2'b00);
    check_eq("full_count", outstanding, MO);
    cycle();
    drive(2'b01, 1'b1, 1'b1, 32'h1);
    #1;
    check_eq("full_pop_no_bypass", mem_req_valid, 0);
    cycle();
    drive(2'b01, 1'b1, 1'b0, '0);
    #1;
    check_eq("full_fire_next", mem_req_valid, 1);
    cycle();
    for (int k = 0; k < int'(MO); k++) begin
      drive('0, 1'b1, 1'b1, DW'(k));
      cycle();
    end

    // Ordering c0, c1, c0 then responses; first response overlaps a push.
    drive(2'b01, 1'b1, 1'b0, '0); cycle();
    drive(2'b10, 1'b1, 1'b0, '0); cycle();
    drive(2'b01, 1'b1, 1'b0, '0); cycle();
    drive(2'b01, 1'b1, 1'b1, 32'hA);
    #1;
    check_eq("order_a", cli_resp_valid, 2'b01);
    cycle();
    check_eq("pushpop_count", outstanding, 3);
    drive('0, 1'b1, 1'b1, 32'hB);
    #1;
    check_eq("order_b", cli_resp_valid, 2'b10);
    check_eq("order_b_data", cli_resp_bits_data, 32'hB);
    cycle();
    drive('0, 1'b1, 1'b1, 32'hC);
    #1;
    check_eq("order_c", cli_resp_valid, 2'b01);
    cycle();
    drive('0, 1'b1, 1'b1, 32'hD);
    cycle();

    // Unexpected response is dropped and sets sticky err.
    drive('0, 1'b1, 1'b1, 32'hE);
    #1;
    check_eq("unexp_resp_valid", cli_resp_valid, 2'b00);
    cycle();
    drive('0, 1'b1, 1'b0, '0);
    cycle();
    #1;
    check_eq("err_sticky", err_unexpected_resp, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check_eq("err_cleared", err_unexpected_resp, 0);

    // Randomised traffic with occasional mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < int'(NC); i++) begin
        if ($urandom_range(0, 3) != 0 || !cli_req_valid[i]) begin
          cli_req_bits_addr[i*AW +: AW] = $urandom;
          cli_req_bits_data[i*DW +: DW] = $urandom;
          cli_req_bits_typ[i*3 +: 3]    = 3'($urandom);
          cli_req_bits_fcn[i]           = 1'($urandom);
        end
      end
      cli_req_valid      = NC'($urandom);
      mem_req_ready      = ($urandom_range(0, 3) != 0);
      mem_resp_valid     = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 127) == 0);
      mem_resp_bits_data = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
